m68k_bus_ctrl: RTL

Synchronous bus slave placed directly downstream of the TG68 68000 core. It turns the core's asynchronous-style strobes (as/uds/lds/rw) into one on-chip word RAM access or one byte-wide GPIO register access per bus cycle. It returns read data on the core's data_in bus and generates dtack after a programmable number of wait states. Every bus cycle completes, unmapped ones included, so the core never hangs.

---
 rtl/m68k_bus_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/m68k_bus_ctrl.sv
// m68k_bus_ctrl
//   Bus slave sitting directly behind the TG68 68000 core. Each strobed bus
//   cycle becomes one access to a local word RAM or to a small byte-wide GPIO
//   block. Every cycle, including unmapped ones, is acknowledged with dtack_n
//   after a fixed number of wait states, so the core can never hang.
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous, active-high
//   as_n      address strobe from core (active-low)
//   uds_n     upper data strobe, bits 15:8 (active-low)
//   lds_n     lower data strobe, bits 7:0 (active-low)
//   rw        1 = read, 0 = write
//   addr      byte address from core (bit 0 unused)
//   cpu_dout  write data from core
//   cpu_din   registered read data to core
//   dtack_n   registered data acknowledge to core (active-low)
//   gpio_in   external input byte, asynchronous to clk
//   gpio_out  external output byte register
module m68k_bus_ctrl #(
    parameter int          ADDR_BITS   = 12,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
    parameter logic [31:0] IO_BASE     = 32'h00FF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        as_n,
    input  logic        uds_n,
    input  logic        lds_n,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    output logic        dtack_n,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_ACK} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [31:1] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic        uds_n_q, uds_n_d;
    logic        lds_n_q, lds_n_d;
    logic [15:0] wdata_q, wdata_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] io_rdata_q, io_rdata_d;
    logic [15:0] cpu_din_q, cpu_din_d;
    logic [7:0]  gpio_out_q, gpio_out_d;
    logic        dtack_n_q, dtack_n_d;
    logic [7:0]  sync1_q, sync1_d;
    logic [7:0]  sync2_q, sync2_d;

    logic [15:0]          mem [0:(1 << ADDR_BITS) - 1];
    logic [15:0]          ram_rdata_q;
    logic                 ram_we;
    logic                 ram_re;
    logic [1:0]           ram_be;
    logic [ADDR_BITS-1:0] ram_idx;
    logic [2:0]           io_idx;
    logic                 ram_hit;
    logic                 io_hit;

    // Bit 0 of the byte address has no meaning on a 16-bit bus.
    logic unused_addr0;
    assign unused_addr0 = addr[0];

    // Decode always works from the address captured in IDLE.
    assign ram_hit = (addr_q[31:ADDR_BITS+1] == RAM_BASE[31:ADDR_BITS+1]);
    assign io_hit  = (addr_q[31:4] == IO_BASE[31:4]);
    assign ram_idx = addr_q[ADDR_BITS:1];
    assign io_idx  = addr_q[3:1];
    assign ram_be  = {~uds_n_q, ~lds_n_q};

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        state_d    = state_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        uds_n_d    = uds_n_q;
        lds_n_d    = lds_n_q;
        wdata_d    = wdata_q;
        wait_cnt_d = wait_cnt_q;
        io_rdata_d = io_rdata_q;
        cpu_din_d  = cpu_din_q;
        gpio_out_d = gpio_out_q;
        sync1_d    = gpio_in;
        sync2_d    = sync1_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // An address strobe without either data strobe is not a cycle.
                if (!as_n && (!uds_n || !lds_n)) begin
                    addr_d  = addr[31:1];
                    rw_d    = rw;
                    uds_n_d = uds_n;
                    lds_n_d = lds_n;
                    wdata_d = cpu_dout;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (!rw_q) begin
                    if (ram_hit) begin
                        ram_we = 1'b1;
                    end else if (io_hit && (io_idx == 3'd0) && !lds_n_q) begin
                        // gpio_out lives on the low lane only.
                        gpio_out_d = wdata_q[7:0];
                    end
                end else begin
                    if (ram_hit) begin
                        ram_re = 1'b1;
                    end else if (io_hit) begin
                        case (io_idx)
                            3'd0:    io_rdata_d = {8'h00, gpio_out_q};
                            3'd1:    io_rdata_d = {8'h00, sync2_q};
                            default: io_rdata_d = 16'h0000;
                        endcase
                    end else begin
                        io_rdata_d = 16'hFFFF;
                    end
                end
                if (WAIT_STATES > 0) begin
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = ST_WAIT;
                end else begin
                    state_d = ST_ACK;
                end
            end

            ST_WAIT: begin
                if (wait_cnt_q <= 4'd1) begin
                    wait_cnt_d = 4'd0;
                    state_d    = ST_ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end

            ST_ACK: begin
                // dtack_n is still high only on the first ACK cycle; loading
                // cpu_din there makes data and dtack_n change on the same edge
                // and keeps cpu_din frozen while the core holds as_n low.
                if (dtack_n_q && rw_q) begin
                    cpu_din_d = ram_hit ? ram_rdata_q : io_rdata_q;
                end
                if (as_n) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Registered from the state, so dtack_n trails ACK by one edge:
        // it falls at T0+2+WAIT_STATES and rises one edge after as_n=1 is seen.
        dtack_n_d = (state_q != ST_ACK);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rw_q       <= 1'b1;
            uds_n_q    <= 1'b1;
            lds_n_q    <= 1'b1;
            wdata_q    <= 16'h0000;
            wait_cnt_q <= 4'd0;
            io_rdata_q <= 16'h0000;
            cpu_din_q  <= 16'h0000;
            gpio_out_q <= 8'h00;
            dtack_n_q  <= 1'b1;
            sync1_q    <= 8'h00;
            sync2_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            uds_n_q    <= uds_n_d;
            lds_n_q    <= lds_n_d;
            wdata_q    <= wdata_d;
            wait_cnt_q <= wait_cnt_d;
            io_rdata_q <= io_rdata_d;
            cpu_din_q  <= cpu_din_d;
            gpio_out_q <= gpio_out_d;
            dtack_n_q  <= dtack_n_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block RAM; reset only
    // gates the write enable, which drops a write caught in ACCESS.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            if (ram_be[1]) mem[ram_idx][15:8] <= wdata_q[15:8];
            if (ram_be[0]) mem[ram_idx][7:0]  <= wdata_q[7:0];
        end
        if (ram_re) begin
            ram_rdata_q <= mem[ram_idx];
        end
    end

    assign cpu_din  = cpu_din_q;
    assign dtack_n  = dtack_n_q;
    assign gpio_out = gpio_out_q;

endmodule
